db_dram_arb: RTL and testbench
==============================

Name: db_dram_arb

Overview:
- Arbitrates the single DRAM port of the key-value store between two requesters.
- Requester 0 is the network lookup/update path (db_cont). Requester 1 is the maintenance/aging engine.
- Serialises commands, allows one outstanding read, routes read data back to its owner, and converts a lost read into an error response after a timeout.
- Sits between the two requesters and the DRAM PHY controller.

Parameters:
- RAM_ADDR, 22, DRAM word address width.
- RAM_DWIDTH, 32, DRAM data width.
- TIMEOUT, 64, cycles waited in RD_WAIT before an error response is issued (≥2).
- CNT_WIDTH, 16, width of the saturating timeout counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 command valid
- req0_ready  out  1  requester 0 command accepted this cycle when valid
- req0_we  in  1  1=write, 0=read
- req0_addr  in  RAM_ADDR  word address
- req0_wdata  in  RAM_DWIDTH  write data
- rsp0_valid  out  1  read response pulse for requester 0
- rsp0_err  out  1  response is a timeout; rsp0_rdata is 0
- rsp0_rdata  out  RAM_DWIDTH  read data
- req1_*, rsp1_*  same set for requester 1
- dram_wr_en  out  1  DRAM write strobe
- dram_rd_en  out  1  DRAM read strobe
- dram_addr  out  RAM_ADDR  DRAM address
- dram_wr_din  out  RAM_DWIDTH  DRAM write data
- dram_rd_dout  in  RAM_DWIDTH  DRAM read data
- dram_rd_valid  in  1  DRAM read data valid
- stat_timeouts  out  CNT_WIDTH  saturating count of read timeouts

Behaviour:
- Clock and reset: single clock clk; rst synchronous, active-high.
- Reset values:
  - State IDLE, last_grant=1 (so requester 0 wins the first contest), timer=0.
  - All dram_* outputs 0; rsp*_valid, rsp*_err and rsp*_rdata 0; stat_timeouts 0.
- Ready rule: reqN_ready is combinational and is 1 only in IDLE for the granted requester.
- Grant in IDLE:
  - Only one requester valid: it is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - Neither valid: no grant, and last_grant is unchanged.
- Accept: on valid&ready, latch owner, we, addr and wdata; set last_grant=owner; go to CMD.
- CMD (exactly 1 cycle):
  - dram_addr=latched addr.
  - If we: dram_wr_en=1 and dram_wr_din=wdata; next state IDLE.
  - If read: dram_rd_en=1; timer cleared; next state RD_WAIT.
  - dram_* outputs are registered. They are 1 only during CMD and return to 0 the next cycle; dram_wr_din and dram_addr may hold their value.
- RD_WAIT:
  - timer increments each cycle.
  - If dram_rd_valid: next cycle rspO_valid=1, rspO_err=0, rspO_rdata=dram_rd_dout (O=owner); go to IDLE.
  - Else if timer==TIMEOUT-1: next cycle rspO_valid=1, rspO_err=1, rspO_rdata=0; stat_timeouts +1 (saturating at all ones); go to IDLE.
  - dram_rd_valid in the same cycle as the timeout: the data response wins and no error is counted.
- Response outputs: registered; valid for exactly one cycle. The non-owner response is never asserted.
- Stray read data: dram_rd_valid outside RD_WAIT is ignored, including late data after a timeout.
- Throughput and latency:
  - Write: accept to dram_wr_en is 1 cycle; one write per 2 cycles per arbiter.
  - Read: response 1 cycle after dram_rd_valid.
  - Back-to-back: a new grant can occur in the IDLE cycle that coincides with rspO_valid.
- Requester inputs are sampled only on the accept cycle. Changes while not ready have no effect.
- Reset mid-operation: any state returns to IDLE; pending reads are dropped with no response; dram strobes go to 0 in the cycle after rst is sampled.

Test Plan:
- Reset, then req0 write addr=0x000010 data=0xDEADBEEF -> req0_ready=1 in cycle 0; cycle 1 dram_wr_en=1, addr=0x000010, din=0xDEADBEEF; cycle 2 strobe 0, IDLE.
- req1 read addr=0x3FFFFF, DRAM returns 0x12345678 three cycles after dram_rd_en -> rsp1_valid=1, rsp1_err=0, rsp1_rdata=0x12345678 one cycle after rd_valid; rsp0_valid stays 0.
- Both requesters hold valid continuously for 6 writes -> grant order 0,1,0,1,0,1; a DRAM strobe every second cycle.
- Read with no dram_rd_valid, TIMEOUT=64 -> rspN_valid=1, rspN_err=1, rdata=0, 65 cycles after dram_rd_en; stat_timeouts=1. A late rd_valid afterwards causes no response.
- dram_rd_valid exactly on the timeout cycle (timer=63) -> data response with err=0; stat_timeouts unchanged.
- Assert rst while in RD_WAIT, then return data -> no response; dram outputs 0; the next contest grants req0 first.

Source files
------------

// File: rtl/db_dram_arb_if.sv
// Bus bundle between the two DRAM requesters, the arbiter and the DRAM PHY controller.
// slave  : the arbiter side.
// master : the environment side (both requesters plus the DRAM controller).
interface db_dram_arb_if #(
  parameter int RAM_ADDR   = 22,
  parameter int RAM_DWIDTH = 32
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic                  req0_we;
  logic [RAM_ADDR-1:0]   req0_addr;
  logic [RAM_DWIDTH-1:0] req0_wdata;
  logic                  rsp0_valid;
  logic                  rsp0_err;
  logic [RAM_DWIDTH-1:0] rsp0_rdata;

  logic                  req1_valid;
  logic                  req1_ready;
  logic                  req1_we;
  logic [RAM_ADDR-1:0]   req1_addr;
  logic [RAM_DWIDTH-1:0] req1_wdata;
  logic                  rsp1_valid;
  logic                  rsp1_err;
  logic [RAM_DWIDTH-1:0] rsp1_rdata;

  logic                  dram_wr_en;
  logic                  dram_rd_en;
  logic [RAM_ADDR-1:0]   dram_addr;
  logic [RAM_DWIDTH-1:0] dram_wr_din;
  logic [RAM_DWIDTH-1:0] dram_rd_dout;
  logic                  dram_rd_valid;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    output req0_ready, rsp0_valid, rsp0_err, rsp0_rdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req1_ready, rsp1_valid, rsp1_err, rsp1_rdata,
    output dram_wr_en, dram_rd_en, dram_addr, dram_wr_din,
    input  dram_rd_dout, dram_rd_valid
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    input  req0_ready, rsp0_valid, rsp0_err, rsp0_rdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req1_ready, rsp1_valid, rsp1_err, rsp1_rdata,
    input  dram_wr_en, dram_rd_en, dram_addr, dram_wr_din,
    output dram_rd_dout, dram_rd_valid
  );
endinterface

// File: rtl/db_dram_arb.sv
// Two-requester arbiter for the key-value store DRAM port.
// Requester 0 is the lookup/update path, requester 1 the aging engine. One command
// at a time, at most one read in flight; a read that never returns is turned into
// an error response after TIMEOUT cycles.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for a command; ready is offered to the granted side
// S_CMD     | registered DRAM strobe is on the bus for this single cycle
// S_RD_WAIT | read issued, waiting for dram_rd_valid or the timeout
module db_dram_arb #(
  parameter int RAM_ADDR   = 22,
  parameter int RAM_DWIDTH = 32,
  parameter int TIMEOUT    = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  db_dram_arb_if.slave         bus,
  output logic [CNT_WIDTH-1:0] stat_timeouts
);

  // Timer only has to reach TIMEOUT-1 before the FSM leaves RD_WAIT.
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]        T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]        T_ONE    = TW'(1);
  localparam logic [CNT_WIDTH-1:0] STAT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CMD     = 2'd1,
    S_RD_WAIT = 2'd2
  } state_t;

  state_t state, next_state;

  logic                  last_grant;
  logic                  owner;
  logic                  cmd_we;
  logic [TW-1:0]         timer;

  logic                  gnt;
  logic                  accept;
  logic                  rdy0;
  logic                  rdy1;
  logic                  sel_we;
  logic [RAM_ADDR-1:0]   sel_addr;
  logic [RAM_DWIDTH-1:0] sel_wdata;
  logic                  timed_out;

  logic                  wr_en_q;
  logic                  rd_en_q;
  logic [RAM_ADDR-1:0]   addr_q;
  logic [RAM_DWIDTH-1:0] din_q;
  logic                  rsp0_valid_q;
  logic                  rsp0_err_q;
  logic [RAM_DWIDTH-1:0] rsp0_rdata_q;
  logic                  rsp1_valid_q;
  logic                  rsp1_err_q;
  logic [RAM_DWIDTH-1:0] rsp1_rdata_q;
  logic [CNT_WIDTH-1:0]  stat_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Grant selection, ready generation and next-state decode.
  always_comb begin
    next_state = state;
    gnt        = 1'b0;
    accept     = 1'b0;
    rdy0       = 1'b0;
    rdy1       = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.req0_valid && bus.req1_valid) begin
          gnt    = ~last_grant;
          accept = 1'b1;
        end else if (bus.req0_valid) begin
          gnt    = 1'b0;
          accept = 1'b1;
        end else if (bus.req1_valid) begin
          gnt    = 1'b1;
          accept = 1'b1;
        end
        rdy0 = accept & ~gnt;
        rdy1 = accept & gnt;
        if (accept) next_state = S_CMD;
      end
      S_CMD: begin
        next_state = cmd_we ? S_IDLE : S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (bus.dram_rd_valid || (timer == T_LAST)) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Mux the granted requester's command fields.
  always_comb begin
    sel_we    = gnt ? bus.req1_we    : bus.req0_we;
    sel_addr  = gnt ? bus.req1_addr  : bus.req0_addr;
    sel_wdata = gnt ? bus.req1_wdata : bus.req0_wdata;
  end

  // Data beats the timeout when both land in the same cycle.
  assign timed_out = (state == S_RD_WAIT) && !bus.dram_rd_valid && (timer == T_LAST);

  // Command capture, DRAM strobes, read-response routing and timeout statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant   <= 1'b1;
      owner        <= 1'b0;
      cmd_we       <= 1'b0;
      timer        <= '0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
      rsp0_valid_q <= 1'b0;
      rsp0_err_q   <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_valid_q <= 1'b0;
      rsp1_err_q   <= 1'b0;
      rsp1_rdata_q <= '0;
      stat_q       <= '0;
    end else begin
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp0_err_q   <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_valid_q <= 1'b0;
      rsp1_err_q   <= 1'b0;
      rsp1_rdata_q <= '0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            owner      <= gnt;
            cmd_we     <= sel_we;
            last_grant <= gnt;
            addr_q     <= sel_addr;
            wr_en_q    <= sel_we;
            rd_en_q    <= ~sel_we;
            if (sel_we) din_q <= sel_wdata;
          end
        end
        S_CMD: begin
          timer <= '0;
        end
        S_RD_WAIT: begin
          timer <= timer + T_ONE;
          if (bus.dram_rd_valid) begin
            if (owner) begin
              rsp1_valid_q <= 1'b1;
              rsp1_rdata_q <= bus.dram_rd_dout;
            end else begin
              rsp0_valid_q <= 1'b1;
              rsp0_rdata_q <= bus.dram_rd_dout;
            end
          end else if (timed_out) begin
            if (owner) begin
              rsp1_valid_q <= 1'b1;
              rsp1_err_q   <= 1'b1;
            end else begin
              rsp0_valid_q <= 1'b1;
              rsp0_err_q   <= 1'b1;
            end
            if (stat_q != '1) stat_q <= stat_q + STAT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready  = rdy0;
  assign bus.req1_ready  = rdy1;
  assign bus.dram_wr_en  = wr_en_q;
  assign bus.dram_rd_en  = rd_en_q;
  assign bus.dram_addr   = addr_q;
  assign bus.dram_wr_din = din_q;
  assign bus.rsp0_valid  = rsp0_valid_q;
  assign bus.rsp0_err    = rsp0_err_q;
  assign bus.rsp0_rdata  = rsp0_rdata_q;
  assign bus.rsp1_valid  = rsp1_valid_q;
  assign bus.rsp1_err    = rsp1_err_q;
  assign bus.rsp1_rdata  = rsp1_rdata_q;
  assign stat_timeouts   = stat_q;

endmodule

// File: tb/tb_db_dram_arb.sv
// Directed bench for db_dram_arb: a table of write contests followed by hand
// sequences for read data, timeout, data-on-timeout and reset during a read.
module tb_db_dram_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] stat;

  int n_pass = 0;
  int n_tot  = 0;

  db_dram_arb_if #(.RAM_ADDR(22), .RAM_DWIDTH(32)) bus ();

  db_dram_arb #(.RAM_ADDR(22), .RAM_DWIDTH(32), .TIMEOUT(64), .CNT_WIDTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .stat_timeouts (stat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic        v1;
    logic [21:0] a0;
    logic [31:0] d0;
    logic [21:0] a1;
    logic [31:0] d1;
    logic        r0;
    logic        r1;
    logic        strobe;
    logic [21:0] exp_addr;
    logic [31:0] exp_din;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic idle_inputs();
    bus.req0_valid    = 1'b0;
    bus.req0_we       = 1'b0;
    bus.req0_addr     = '0;
    bus.req0_wdata    = '0;
    bus.req1_valid    = 1'b0;
    bus.req1_we       = 1'b0;
    bus.req1_addr     = '0;
    bus.req1_wdata    = '0;
    bus.dram_rd_valid = 1'b0;
    bus.dram_rd_dout  = '0;
  endtask

  initial begin
    int lat;
    logic [21:0] exp_a;

    // last_grant starts at 1, so contests go 0 then alternate.
    vecs[0] = '{1, 0, 22'h000010, 32'hDEADBEEF, 22'h000020, 32'h11111111, 1, 0, 1, 22'h000010, 32'hDEADBEEF};
    vecs[1] = '{1, 1, 22'h000011, 32'hA0A0A0A0, 22'h000021, 32'hB1B1B1B1, 0, 1, 1, 22'h000021, 32'hB1B1B1B1};
    vecs[2] = '{1, 1, 22'h000012, 32'hA2A2A2A2, 22'h000022, 32'hB2B2B2B2, 1, 0, 1, 22'h000012, 32'hA2A2A2A2};
    vecs[3] = '{0, 1, 22'h000013, 32'hA3A3A3A3, 22'h000023, 32'hB3B3B3B3, 0, 1, 1, 22'h000023, 32'hB3B3B3B3};
    vecs[4] = '{0, 1, 22'h000014, 32'hA4A4A4A4, 22'h000024, 32'hB4B4B4B4, 0, 1, 1, 22'h000024, 32'hB4B4B4B4};
    vecs[5] = '{1, 1, 22'h000015, 32'hA5A5A5A5, 22'h000025, 32'hB5B5B5B5, 1, 0, 1, 22'h000015, 32'hA5A5A5A5};
    vecs[6] = '{0, 0, 22'h000016, 32'hA6A6A6A6, 22'h000026, 32'hB6B6B6B6, 0, 0, 0, 22'h000000, 32'h00000000};
    vecs[7] = '{1, 1, 22'h000017, 32'hA7A7A7A7, 22'h000027, 32'hB7B7B7B7, 0, 1, 1, 22'h000027, 32'hB7B7B7B7};

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("reset_wr_en", 32'(bus.dram_wr_en), 32'd0);
    chk("reset_rd_en", 32'(bus.dram_rd_en), 32'd0);
    chk("reset_addr", 32'(bus.dram_addr), 32'd0);
    chk("reset_rsp0", 32'({bus.rsp0_valid, bus.rsp0_err}), 32'd0);
    chk("reset_rsp1", 32'({bus.rsp1_valid, bus.rsp1_err}), 32'd0);
    chk("reset_stat", 32'(stat), 32'd0);
    chk("reset_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);

    // Table of write contests, two cycles per entry.
    for (int i = 0; i < 8; i++) begin
      bus.req0_valid = vecs[i].v0;
      bus.req0_we    = 1'b1;
      bus.req0_addr  = vecs[i].a0;
      bus.req0_wdata = vecs[i].d0;
      bus.req1_valid = vecs[i].v1;
      bus.req1_we    = 1'b1;
      bus.req1_addr  = vecs[i].a1;
      bus.req1_wdata = vecs[i].d1;
      #1;
      chk($sformatf("vec%0d_ready0", i), 32'(bus.req0_ready), 32'(vecs[i].r0));
      chk($sformatf("vec%0d_ready1", i), 32'(bus.req1_ready), 32'(vecs[i].r1));
      tick();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      chk($sformatf("vec%0d_wr_en", i), 32'(bus.dram_wr_en), 32'(vecs[i].strobe));
      chk($sformatf("vec%0d_rd_en", i), 32'(bus.dram_rd_en), 32'd0);
      if (vecs[i].strobe) begin
        chk($sformatf("vec%0d_addr", i), 32'(bus.dram_addr), 32'(vecs[i].exp_addr));
        chk($sformatf("vec%0d_din", i), bus.dram_wr_din, vecs[i].exp_din);
      end
      tick();
      chk($sformatf("vec%0d_wr_en_off", i), 32'(bus.dram_wr_en), 32'd0);
    end

    // req1 read, data returned three cycles after the strobe.
    bus.req1_valid = 1'b1;
    bus.req1_we    = 1'b0;
    bus.req1_addr  = 22'h3FFFFF;
    #1;
    chk("rd1_ready", 32'(bus.req1_ready), 32'd1);
    tick();
    bus.req1_valid = 1'b0;
    chk("rd1_rd_en", 32'(bus.dram_rd_en), 32'd1);
    chk("rd1_addr", 32'(bus.dram_addr), 32'h3FFFFF);
    chk("rd1_wr_en", 32'(bus.dram_wr_en), 32'd0);
    tick();
    chk("rd1_rd_en_off", 32'(bus.dram_rd_en), 32'd0);
    tick();
    tick();
    bus.dram_rd_valid = 1'b1;
    bus.dram_rd_dout  = 32'h12345678;
    chk("rd1_no_early_rsp", 32'(bus.rsp1_valid), 32'd0);
    tick();
    bus.dram_rd_valid = 1'b0;
    bus.dram_rd_dout  = '0;
    chk("rd1_rsp_valid", 32'(bus.rsp1_valid), 32'd1);
    chk("rd1_rsp_err", 32'(bus.rsp1_err), 32'd0);
    chk("rd1_rsp_rdata", bus.rsp1_rdata, 32'h12345678);
    chk("rd1_rsp0_quiet", 32'(bus.rsp0_valid), 32'd0);
    tick();
    chk("rd1_rsp_pulse", 32'(bus.rsp1_valid), 32'd0);

    // Both sides stream writes; strobe every other cycle, order 0,1,0,1,0,1.
    bus.req0_valid = 1'b1;
    bus.req0_we    = 1'b1;
    bus.req0_addr  = 22'h000100;
    bus.req0_wdata = 32'h00000100;
    bus.req1_valid = 1'b1;
    bus.req1_we    = 1'b1;
    bus.req1_addr  = 22'h000200;
    bus.req1_wdata = 32'h00000200;
    for (int k = 0; k < 12; k++) begin
      if (k == 11) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      tick();
      if (k % 2 == 0) begin
        exp_a = ((k / 2) % 2 == 0) ? 22'h000100 : 22'h000200;
        chk($sformatf("stream%0d_wr_en", k), 32'(bus.dram_wr_en), 32'd1);
        chk($sformatf("stream%0d_owner", k), 32'(bus.dram_addr), 32'(exp_a));
      end else begin
        chk($sformatf("stream%0d_gap", k), 32'(bus.dram_wr_en), 32'd0);
      end
    end
    tick();
    chk("stream_done", 32'(bus.dram_wr_en), 32'd0);

    // req0 read that never returns: error response 65 cycles after the strobe.
    bus.req0_valid = 1'b1;
    bus.req0_we    = 1'b0;
    bus.req0_addr  = 22'h000055;
    tick();
    bus.req0_valid = 1'b0;
    chk("to_rd_en", 32'(bus.dram_rd_en), 32'd1);
    lat = -1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (bus.rsp0_valid) begin
        lat = k;
        break;
      end
    end
    chk("to_latency", 32'(lat), 32'd65);
    chk("to_err", 32'(bus.rsp0_err), 32'd1);
    chk("to_rdata", bus.rsp0_rdata, 32'd0);
    chk("to_rsp1_quiet", 32'(bus.rsp1_valid), 32'd0);
    chk("to_stat", 32'(stat), 32'd1);
    bus.dram_rd_valid = 1'b1;
    bus.dram_rd_dout  = 32'hBADBAD00;
    tick();
    bus.dram_rd_valid = 1'b0;
    chk("late_none_a", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
    tick();
    chk("late_none_b", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);

    // req1 read with data landing on the timeout cycle: data wins.
    bus.req1_valid = 1'b1;
    bus.req1_we    = 1'b0;
    bus.req1_addr  = 22'h000077;
    tick();
    bus.req1_valid = 1'b0;
    chk("edge_rd_en", 32'(bus.dram_rd_en), 32'd1);
    for (int k = 0; k < 64; k++) tick();
    chk("edge_no_early_rsp", 32'(bus.rsp1_valid), 32'd0);
    bus.dram_rd_valid = 1'b1;
    bus.dram_rd_dout  = 32'hCAFEF00D;
    tick();
    bus.dram_rd_valid = 1'b0;
    chk("edge_rsp_valid", 32'(bus.rsp1_valid), 32'd1);
    chk("edge_rsp_err", 32'(bus.rsp1_err), 32'd0);
    chk("edge_rsp_rdata", bus.rsp1_rdata, 32'hCAFEF00D);
    chk("edge_stat", 32'(stat), 32'd1);
    tick();
    chk("edge_single", 32'(bus.rsp1_valid), 32'd0);

    // req0 read, reset while waiting; last_grant becomes 0 before the reset.
    bus.req0_valid = 1'b1;
    bus.req0_we    = 1'b0;
    bus.req0_addr  = 22'h000099;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_rd_en", 32'(bus.dram_rd_en), 32'd0);
    chk("rst_wr_en", 32'(bus.dram_wr_en), 32'd0);
    chk("rst_addr", 32'(bus.dram_addr), 32'd0);
    chk("rst_stat", 32'(stat), 32'd0);
    bus.dram_rd_valid = 1'b1;
    bus.dram_rd_dout  = 32'h0BADF00D;
    tick();
    bus.dram_rd_valid = 1'b0;
    chk("rst_drop_a", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
    tick();
    chk("rst_drop_b", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
    bus.req0_valid = 1'b1;
    bus.req0_we    = 1'b1;
    bus.req0_addr  = 22'h000301;
    bus.req1_valid = 1'b1;
    bus.req1_we    = 1'b1;
    bus.req1_addr  = 22'h000302;
    #1;
    chk("rst_grant0", 32'({bus.req0_ready, bus.req1_ready}), 32'b10);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("rst_grant_addr", 32'(bus.dram_addr), 32'h000301);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
